// File: rtl/lpc_host_sequencer.sv
// Host-side LPC I/O cycle sequencer: round-robin arbitration of single-byte
// I/O read/write requests and START/CTDIR/ADDR/TAR/SYNC/DATA framing on LAD.
module lpc_host_sequencer #(
  parameter int unsigned N        = 2,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic              lpc_clk,
  input  logic              lpc_rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N-1:0]      req_write,
  input  logic [16*N-1:0]   req_addr,
  input  logic [8*N-1:0]    req_wdata,
  output logic [N-1:0]      rsp_done,
  output logic [7:0]        rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              lpc_frame,
  output logic [3:0]        lpc_data_out,
  output logic              lpc_data_oe,
  input  logic [3:0]        lpc_data_in
);

  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [4:0] {
    ST_IDLE, ST_START, ST_CTDIR,
    ST_ADDR0, ST_ADDR1, ST_ADDR2, ST_ADDR3,
    ST_WDATA0, ST_WDATA1, ST_HTAR0, ST_HTAR1, ST_SYNC,
    ST_RDATA0, ST_RDATA1, ST_PTAR0, ST_PTAR1,
    ST_ABORT0, ST_ABORT1, ST_ABORT2, ST_ABORT3, ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, win_q, grant_idx;
  logic                grant_vld;
  logic                write_q, sel_write;
  logic [15:0]         addr_q, sel_addr;
  logic [7:0]          wdata_q, sel_wdata;
  logic [7:0]          data_q;
  logic                err_q;
  logic [WAIT_W-1:0]   wait_q;

  logic                frame_q, frame_d;
  logic                oe_q, oe_d;
  logic [3:0]          lad_q, lad_d;
  logic                busy_q, busy_d;
  logic [N-1:0]        done_q, done_d;
  logic [7:0]          rdata_q;
  logic                rerr_q;

  // Round-robin: first valid requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_q) + k) % N;
      if (!grant_vld && req_valid[IDX_W'(j)]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (IDX_W'(k) == grant_idx) begin
        sel_addr  = req_addr[16*k +: 16];
        sel_wdata = req_wdata[8*k +: 8];
        sel_write = req_write[k];
      end
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (!lpc_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_vld) state_d = ST_START;
      ST_START:  state_d = ST_CTDIR;
      ST_CTDIR:  state_d = ST_ADDR0;
      ST_ADDR0:  state_d = ST_ADDR1;
      ST_ADDR1:  state_d = ST_ADDR2;
      ST_ADDR2:  state_d = ST_ADDR3;
      ST_ADDR3:  state_d = write_q ? ST_WDATA0 : ST_HTAR0;
      ST_WDATA0: state_d = ST_WDATA1;
      ST_WDATA1: state_d = ST_HTAR0;
      ST_HTAR0:  state_d = ST_HTAR1;
      ST_HTAR1:  state_d = ST_SYNC;
      ST_SYNC: begin
        if (lpc_data_in == 4'h0)                   state_d = write_q ? ST_PTAR0 : ST_RDATA0;
        else if (lpc_data_in == 4'hA)              state_d = ST_PTAR0;
        else if (wait_q == WAIT_W'(MAX_WAIT - 1))  state_d = ST_ABORT0;
      end
      ST_RDATA0: state_d = ST_RDATA1;
      ST_RDATA1: state_d = ST_PTAR0;
      ST_PTAR0:  state_d = ST_PTAR1;
      ST_PTAR1:  state_d = ST_DONE;
      ST_ABORT0: state_d = ST_ABORT1;
      ST_ABORT1: state_d = ST_ABORT2;
      ST_ABORT2: state_d = ST_ABORT3;
      ST_ABORT3: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Decoded from the next state so the registered pins line up with state_q.
  always_comb begin
    frame_d = 1'b1;
    oe_d    = 1'b1;
    lad_d   = 4'hF;
    busy_d  = 1'b1;
    done_d  = '0;
    case (state_d)
      ST_IDLE:   begin oe_d = 1'b0; busy_d = 1'b0; end
      ST_START:  begin frame_d = 1'b0; lad_d = 4'h0; end
      ST_CTDIR:  lad_d = write_q ? 4'h2 : 4'h0;
      ST_ADDR0:  lad_d = addr_q[15:12];
      ST_ADDR1:  lad_d = addr_q[11:8];
      ST_ADDR2:  lad_d = addr_q[7:4];
      ST_ADDR3:  lad_d = addr_q[3:0];
      ST_WDATA0: lad_d = wdata_q[3:0];
      ST_WDATA1: lad_d = wdata_q[7:4];
      ST_HTAR0:  lad_d = 4'hF;
      ST_HTAR1, ST_SYNC, ST_RDATA0, ST_RDATA1, ST_PTAR0, ST_PTAR1:
                 oe_d = 1'b0;
      ST_ABORT0, ST_ABORT1, ST_ABORT2, ST_ABORT3:
                 frame_d = 1'b0;
      ST_DONE:   begin oe_d = 1'b0; busy_d = 1'b0; done_d = N'(1) << win_q; end
      default:   begin oe_d = 1'b0; busy_d = 1'b0; end
    endcase
  end

  always_ff @(posedge lpc_clk) begin
    if (!lpc_rst) begin
      ptr_q   <= '0;
      win_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wait_q  <= '0;
      frame_q <= 1'b1;
      oe_q    <= 1'b0;
      lad_q   <= 4'hF;
      busy_q  <= 1'b0;
      done_q  <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      frame_q <= frame_d;
      oe_q    <= oe_d;
      lad_q   <= lad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_d == ST_DONE) begin
        rdata_q <= data_q;
        rerr_q  <= err_q;
      end
      case (state_q)
        ST_IDLE: if (grant_vld) begin
          win_q   <= grant_idx;
          write_q <= sel_write;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          data_q  <= '0;
          err_q   <= 1'b0;
          wait_q  <= '0;
        end
        ST_SYNC: begin
          if (lpc_data_in == 4'hA) begin
            err_q  <= 1'b1;
            data_q <= 8'hFF;
          end else if (lpc_data_in != 4'h0) begin
            wait_q <= wait_q + WAIT_W'(1);
          end
        end
        ST_RDATA0: data_q[3:0] <= lpc_data_in;
        ST_RDATA1: data_q[7:4] <= lpc_data_in;
        ST_ABORT0: begin
          err_q  <= 1'b1;
          data_q <= 8'hFF;
        end
        ST_DONE:   ptr_q <= (win_q == IDX_W'(N - 1)) ? '0 : win_q + IDX_W'(1);
        default:   ;
      endcase
    end
  end

  assign rsp_done     = done_q;
  assign rsp_rdata    = rdata_q;
  assign rsp_err      = rerr_q;
  assign busy         = busy_q;
  assign lpc_frame    = frame_q;
  assign lpc_data_out = lad_q;
  assign lpc_data_oe  = oe_q;

endmodule

// File: tb/tb_lpc_host_sequencer.sv
// Directed bench for lpc_host_sequencer: cycle-by-cycle LAD/frame/oe/busy/done
// expectations built from hand-written transaction tables.
module tb_lpc_host_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_write, rsp_done;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [7:0]  rsp_rdata;
  logic        rsp_err, busy, lpc_frame, lpc_data_oe;
  logic [3:0]  lpc_data_out, lpc_data_in;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];
  logic [3:0] lin_q[$];

  always #5 clk = ~clk;

  lpc_host_sequencer #(.N(2), .MAX_WAIT(16)) dut (
    .lpc_clk(clk), .lpc_rst(rst_n),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .lpc_frame(lpc_frame),
    .lpc_data_out(lpc_data_out), .lpc_data_oe(lpc_data_oe),
    .lpc_data_in(lpc_data_in)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One expected cycle: LAD input to present, then {done, busy, frame, oe, lad}.
  task automatic e(input logic [3:0] lin, input logic [1:0] dn, input logic b,
                   input logic f, input logic o, input logic [3:0] lad);
    exp_q.push_back({dn, b, f, o, lad});
    lin_q.push_back(lin);
  endtask

  task automatic push_hdr(input logic wr, input logic [15:0] a, input logic [7:0] d);
    e(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 4'hF);
    e(4'h0, 2'b00, 1'b1, 1'b0, 1'b1, 4'h0);
    e(4'h0, 2'b00, 1'b1, 1'b1, 1'b1, wr ? 4'h2 : 4'h0);
    for (int i = 0; i < 4; i++) e(4'h0, 2'b00, 1'b1, 1'b1, 1'b1, a[4*(3-i) +: 4]);
    if (wr) begin
      e(4'h0, 2'b00, 1'b1, 1'b1, 1'b1, d[3:0]);
      e(4'h0, 2'b00, 1'b1, 1'b1, 1'b1, d[7:4]);
    end
    e(4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 4'hF);
    e(4'h0, 2'b00, 1'b1, 1'b1, 1'b0, 4'hF);
  endtask

  task automatic push_in(input logic [3:0] lin);
    e(lin, 2'b00, 1'b1, 1'b1, 1'b0, 4'hF);
  endtask

  task automatic push_abort();
    for (int i = 0; i < 4; i++) e(4'hF, 2'b00, 1'b1, 1'b0, 1'b1, 4'hF);
  endtask

  task automatic push_done(input logic [1:0] dn);
    e(4'h0, dn, 1'b0, 1'b1, 1'b0, 4'hF);
  endtask

  // Zero-wait write: header, SYNC=0, two PTAR, DONE.
  task automatic push_write(input logic [15:0] a, input logic [7:0] d, input logic [1:0] dn);
    push_hdr(1'b1, a, d);
    push_in(4'h0);
    push_in(4'h0);
    push_in(4'h0);
    push_done(dn);
  endtask

  // Plays the queued cycles; returns while still in the last (DONE) cycle.
  task automatic run(input string tag);
    int i;
    logic [8:0] ex;
    i = 0;
    while (exp_q.size() > 0) begin
      ex          = exp_q.pop_front();
      lpc_data_in = lin_q.pop_front();
      chk($sformatf("%s_c%0d", tag, i + 1),
          {23'd0, rsp_done, busy, lpc_frame, lpc_data_oe, lpc_data_out}, {23'd0, ex});
      i++;
      if (exp_q.size() > 0) step();
    end
  endtask

  task automatic idle_check(input string tag);
    chk(tag, {23'd0, rsp_done, busy, lpc_frame, lpc_data_oe, lpc_data_out},
        {23'd0, 2'b00, 1'b0, 1'b1, 1'b0, 4'hF});
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    lpc_data_in = 4'hF;
    step();
    step();
    idle_check("reset_bus");
    chk("reset_rdata", 32'(rsp_rdata), 32'h00);
    chk("reset_err",   32'(rsp_err),   32'h0);
    rst_n = 1'b1;
    step();

    // Read 0x03FD from req0, SYNC ready at once, data 0x60.
    req_addr  = {16'h0000, 16'h03FD};
    req_write = 2'b00;
    req_valid = 2'b01;
    push_hdr(1'b0, 16'h03FD, 8'h00);
    push_in(4'h0);
    push_in(4'h0);
    push_in(4'h6);
    push_in(4'h0);
    push_in(4'h0);
    push_done(2'b01);
    run("rd");
    chk("rd_rdata", 32'(rsp_rdata), 32'h60);
    chk("rd_err",   32'(rsp_err),   32'h0);
    req_valid = '0;
    step();
    idle_check("rd_idle");

    // Write 0xA5 to 0x03F8 from req1 with three SYNC=6 waits.
    req_addr  = {16'h03F8, 16'h0000};
    req_wdata = {8'hA5, 8'h00};
    req_write = 2'b10;
    req_valid = 2'b10;
    push_hdr(1'b1, 16'h03F8, 8'hA5);
    push_in(4'h6);
    push_in(4'h6);
    push_in(4'h6);
    push_in(4'h0);
    push_in(4'h0);
    push_in(4'h0);
    push_done(2'b10);
    run("wr");
    chk("wr_rdata", 32'(rsp_rdata), 32'h00);
    chk("wr_err",   32'(rsp_err),   32'h0);
    req_valid = '0;
    step();
    idle_check("wr_idle");

    // Both requesters continuously valid: order req0, req1, req0.
    req_addr  = {16'hABCD, 16'h1234};
    req_wdata = {8'h71, 8'h5C};
    req_write = 2'b11;
    req_valid = 2'b11;
    push_write(16'h1234, 8'h5C, 2'b01);
    push_write(16'hABCD, 8'h71, 2'b10);
    push_write(16'h1234, 8'h5C, 2'b01);
    run("rr");
    chk("rr_err", 32'(rsp_err), 32'h0);
    req_valid = '0;
    step();
    idle_check("rr_idle");

    // No peripheral: SYNC stuck at F until abort.
    req_addr  = {16'h0000, 16'h0080};
    req_write = 2'b00;
    req_valid = 2'b01;
    push_hdr(1'b0, 16'h0080, 8'h00);
    for (int i = 0; i < 16; i++) push_in(4'hF);
    push_abort();
    push_done(2'b01);
    run("ab");
    chk("ab_rdata", 32'(rsp_rdata), 32'hFF);
    chk("ab_err",   32'(rsp_err),   32'h1);
    req_valid = '0;
    step();
    idle_check("ab_idle");
    chk("ab_hold_rdata", 32'(rsp_rdata), 32'hFF);

    // SYNC error on a read: no RDATA cycles, error reported.
    req_addr  = {16'h0000, 16'h0060};
    req_valid = 2'b01;
    push_hdr(1'b0, 16'h0060, 8'h00);
    push_in(4'hA);
    push_in(4'h0);
    push_in(4'h0);
    push_done(2'b01);
    run("se");
    chk("se_err", 32'(rsp_err), 32'h1);
    req_valid = '0;
    step();
    idle_check("se_idle");

    // Reset during ADDR2 of a req0 read.
    req_addr  = {16'h0000, 16'h1111};
    req_valid = 2'b01;
    push_hdr(1'b0, 16'h1111, 8'h00);
    void'(exp_q.pop_back());
    void'(lin_q.pop_back());
    void'(exp_q.pop_back());
    void'(lin_q.pop_back());
    void'(exp_q.pop_back());
    void'(lin_q.pop_back());
    run("rs");
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    idle_check("rs_bus");
    chk("rs_rdata", 32'(rsp_rdata), 32'h00);
    chk("rs_err",   32'(rsp_err),   32'h0);
    rst_n = 1'b1;
    step();
    idle_check("rs_after");

    // Fresh contention after reset: pointer 0 so req0 read wins.
    req_addr  = {16'hBEEF, 16'h0070};
    req_wdata = {8'h33, 8'h00};
    req_write = 2'b10;
    req_valid = 2'b11;
    push_hdr(1'b0, 16'h0070, 8'h00);
    push_in(4'h0);
    push_in(4'h9);
    push_in(4'h3);
    push_in(4'h0);
    push_in(4'h0);
    push_done(2'b01);
    run("fr");
    chk("fr_rdata", 32'(rsp_rdata), 32'h39);
    chk("fr_err",   32'(rsp_err),   32'h0);
    req_valid = '0;
    step();
    idle_check("fr_idle");
    step();
    idle_check("fr_idle2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
